// File: rtl/atm_pin_verifier_pkg.sv
// Shared types, widths and the stored-PIN rule for the ATM PIN verifier.
package atm_pin_verifier_pkg;

    localparam int DIGIT_W = 4;
    localparam int COD_W   = 5;
    localparam int TEMPO_W = 9;
    localparam int TRIES_W = 2;
    localparam int IDX_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_GRANTED = 3'd3,
        ST_LOCKED  = 3'd4
    } state_e;

    // Stored PIN digit for slot idx of account cod: (cod + idx) mod 10.
    function automatic logic [DIGIT_W-1:0] stored_digit(input logic [COD_W-1:0] cod,
                                                        input logic [IDX_W-1:0] idx);
        logic [5:0] sum;
        sum = {1'b0, cod} + {3'b000, idx};
        return DIGIT_W'(sum % 6'd10);
    endfunction

endpackage

// File: rtl/atm_pin_verifier_if.sv
// Keypad/card front-end to PIN verifier bus; master drives entry, slave answers status.
interface atm_pin_verifier_if;
    import atm_pin_verifier_pkg::*;

    logic                card_valid;
    logic [COD_W-1:0]    cod;
    logic [DIGIT_W-1:0]  pin_digit;
    logic                digit_strobe;
    logic                confirm;
    logic                cancel;
    logic                auth_ok;
    logic                auth_fail;
    logic                locked;
    logic                timeout;
    logic [TRIES_W-1:0]  tries_left;
    logic [TEMPO_W-1:0]  tempo;

    modport master (
        output card_valid, cod, pin_digit, digit_strobe, confirm, cancel,
        input  auth_ok, auth_fail, locked, timeout, tries_left, tempo
    );

    modport slave (
        input  card_valid, cod, pin_digit, digit_strobe, confirm, cancel,
        output auth_ok, auth_fail, locked, timeout, tries_left, tempo
    );

endinterface

// File: rtl/atm_pin_verifier_rom.sv
// Combinational stored-PIN lookup: one instance per digit slot.
module atm_pin_rom
    import atm_pin_verifier_pkg::*;
(
    input  logic [COD_W-1:0]   cod,
    input  logic [IDX_W-1:0]   idx,
    output logic [DIGIT_W-1:0] digit
);

    assign digit = stored_digit(cod, idx);

endmodule

// File: rtl/atm_pin_verifier.sv
// ATM PIN verifier: session FSM, digit buffer, tries counter, idle timer and per-account lock bits.
module atm_pin_verifier
    import atm_pin_verifier_pkg::*;
#(
    parameter int PIN_LEN   = 4,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 300
)(
    input  logic                clk,
    input  logic                rst_n,
    atm_pin_verifier_if.slave   bus
);

    localparam int CNT_W = $clog2(PIN_LEN + 1);

    state_e                          state_r, state_s;
    logic [COD_W-1:0]                cod_r, cod_s;
    logic [CNT_W-1:0]                cnt_r, cnt_s;
    logic [PIN_LEN-1:0][DIGIT_W-1:0] buf_r, buf_s;
    logic [PIN_LEN-1:0][DIGIT_W-1:0] rom_s;
    logic [TRIES_W-1:0]              tries_r, tries_s;
    logic [TEMPO_W-1:0]              tempo_r, tempo_s;
    logic [31:0]                     lock_r, lock_s;
    logic                            fail_s, to_s, match_s;
    logic                            auth_ok_r, auth_fail_r, locked_r, timeout_r;

    for (genvar g = 0; g < PIN_LEN; g++) begin : g_rom
        atm_pin_rom u_rom (
            .cod   (cod_r),
            .idx   (IDX_W'(g)),
            .digit (rom_s[g])
        );
    end

    // Entry matches only when complete and every slot equals the stored digit.
    always_comb begin
        match_s = (cnt_r == CNT_W'(PIN_LEN));
        for (int i = 0; i < PIN_LEN; i++) begin
            match_s = match_s & (buf_r[i] == rom_s[i]);
        end
    end

    // Next-state and datapath updates; card removal overrides everything.
    always_comb begin
        state_s = state_r;
        cod_s   = cod_r;
        cnt_s   = cnt_r;
        buf_s   = buf_r;
        tries_s = tries_r;
        tempo_s = tempo_r;
        lock_s  = lock_r;
        fail_s  = 1'b0;
        to_s    = 1'b0;
        if (!bus.card_valid) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            tries_s = 2'd0;
            tempo_s = 9'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cod_s = bus.cod;
                    cnt_s = '0;
                    buf_s = '0;
                    if (lock_r[bus.cod]) begin
                        state_s = ST_LOCKED;
                        tries_s = 2'd0;
                        tempo_s = 9'd0;
                    end else begin
                        state_s = ST_COLLECT;
                        tries_s = TRIES_W'(MAX_TRIES);
                        tempo_s = TEMPO_W'(TIMEOUT);
                    end
                end
                ST_COLLECT: begin
                    if (bus.cancel) begin
                        state_s = ST_IDLE;
                        tries_s = 2'd0;
                        tempo_s = 9'd0;
                    end else if (bus.confirm) begin
                        state_s = ST_CHECK;
                        tempo_s = 9'd0;
                    end else if (bus.digit_strobe && (bus.pin_digit <= 4'd9) &&
                                 (cnt_r < CNT_W'(PIN_LEN))) begin
                        for (int i = 0; i < PIN_LEN; i++) begin
                            if (cnt_r == CNT_W'(i)) begin
                                buf_s[i] = bus.pin_digit;
                            end else begin
                                buf_s[i] = buf_r[i];
                            end
                        end
                        cnt_s   = cnt_r + CNT_W'(1);
                        tempo_s = TEMPO_W'(TIMEOUT);
                    end else if (tempo_r == 9'd1) begin
                        to_s    = 1'b1;
                        state_s = ST_IDLE;
                        tries_s = 2'd0;
                        tempo_s = 9'd0;
                    end else begin
                        tempo_s = tempo_r - 9'd1;
                    end
                end
                ST_CHECK: begin
                    if (match_s) begin
                        state_s = ST_GRANTED;
                    end else begin
                        fail_s  = 1'b1;
                        tries_s = tries_r - 2'd1;
                        if (tries_r == 2'd1) begin
                            lock_s[cod_r] = 1'b1;
                            state_s       = ST_LOCKED;
                        end else begin
                            state_s = ST_COLLECT;
                            cnt_s   = '0;
                            buf_s   = '0;
                            tempo_s = TEMPO_W'(TIMEOUT);
                        end
                    end
                end
                ST_GRANTED: begin
                    state_s = ST_GRANTED;
                end
                ST_LOCKED: begin
                    state_s = ST_LOCKED;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    tries_s = 2'd0;
                    tempo_s = 9'd0;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cod_r       <= 5'd0;
            cnt_r       <= '0;
            buf_r       <= '0;
            tries_r     <= 2'd0;
            tempo_r     <= 9'd0;
            lock_r      <= 32'd0;
            auth_ok_r   <= 1'b0;
            auth_fail_r <= 1'b0;
            locked_r    <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cod_r       <= cod_s;
            cnt_r       <= cnt_s;
            buf_r       <= buf_s;
            tries_r     <= tries_s;
            tempo_r     <= tempo_s;
            lock_r      <= lock_s;
            auth_ok_r   <= (state_s == ST_GRANTED);
            auth_fail_r <= fail_s;
            locked_r    <= (state_s == ST_LOCKED);
            timeout_r   <= to_s;
        end
    end

    assign bus.auth_ok    = auth_ok_r;
    assign bus.auth_fail  = auth_fail_r;
    assign bus.locked     = locked_r;
    assign bus.timeout    = timeout_r;
    assign bus.tries_left = tries_r;
    assign bus.tempo      = tempo_r;

endmodule
